// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream handshake plus instruction-memory write port of the program loader.
// Signals: in_data/in_valid/in_ready (stream), mem_data/mem_addr/mem_en_write (memory write port).
// master = the loader (accepts the stream, drives memory); slave = the stream source / memory side.
interface program_loader_if #(
   parameter int INST_SIZE = 16,
   parameter int ADDR_SIZE = 8
);
   logic [7:0]           in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [INST_SIZE-1:0] mem_data;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic                 mem_en_write;

   modport master (
      input  in_data, in_valid,
      output in_ready, mem_data, mem_addr, mem_en_write
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, mem_data, mem_addr, mem_en_write
   );
endinterface

// File: rtl/program_loader.sv
// program_loader: loads a count/instructions/checksum byte stream into instruction memory and holds the CPU in reset until it verifies.
// Latency: write strobe the cycle after a word's last byte; in_ready returns one cycle later; cpu_rst falls the cycle after a good checksum.
// Backpressure: in_ready is low during each write cycle and in DONE/ERROR; the source holds its byte until accepted.
// Ports: clk, rst (synchronous, active-high); bus.master = stream in + memory write out; cpu_rst/done/error = status, all registered.
module program_loader #(
   parameter int INST_SIZE = 16,
   parameter int ADDR_SIZE = 8
) (
   input  logic             clk,
   input  logic             rst,
   program_loader_if.master bus,
   output logic             cpu_rst,
   output logic             done,
   output logic             error
);
   localparam int BYTES_PER_INST = INST_SIZE / 8;
   localparam int BC_W           = (BYTES_PER_INST > 1) ? $clog2(BYTES_PER_INST) : 1;

   typedef enum logic [2:0] {
      S_COUNT,
      S_RECV,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t               state_q;
   logic                 in_ready_q;
   logic                 mem_en_write_q;
   logic [ADDR_SIZE-1:0] mem_addr_q;
   logic [INST_SIZE-1:0] mem_data_q;
   logic                 cpu_rst_q;
   logic                 done_q;
   logic                 error_q;

   logic [7:0]           n_q;       // instruction count from the header byte
   logic [7:0]           csum_q;    // running XOR of instruction bytes
   logic [INST_SIZE-1:0] word_q;    // word being assembled, MSB first
   logic [BC_W-1:0]      bcnt_q;    // byte index within the current word
   logic [ADDR_SIZE:0]   wcnt_q;    // one extra bit so N = 2^ADDR_SIZE does not alias to 0

   logic                 accept;
   logic [INST_SIZE-1:0] word_d;
   logic [7:0]           csum_d;
   logic [ADDR_SIZE:0]   wcnt_d;
   logic                 last_byte;
   logic                 n_too_big;
   logic                 words_done;

   assign accept     = bus.in_valid && in_ready_q;
   assign word_d     = (word_q << 8) | INST_SIZE'(bus.in_data);
   assign csum_d     = csum_q ^ bus.in_data;
   assign wcnt_d     = wcnt_q + 1'b1;
   assign last_byte  = (bcnt_q == BC_W'(BYTES_PER_INST - 1));
   // Only possible for ADDR_SIZE < 8; compared in 9 bits so 2^8 is representable.
   assign n_too_big  = ({1'b0, bus.in_data} > (9'd1 << ADDR_SIZE));
   assign words_done = (9'(wcnt_d) == {1'b0, n_q});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_COUNT;
         in_ready_q     <= 1'b0;
         mem_en_write_q <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_q     <= '0;
         cpu_rst_q      <= 1'b1;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         n_q            <= '0;
         csum_q         <= '0;
         word_q         <= '0;
         bcnt_q         <= '0;
         wcnt_q         <= '0;
      end else begin
         case (state_q)
            S_COUNT: begin
               // Ready comes up the cycle after reset is released.
               in_ready_q <= 1'b1;
               if (accept) begin
                  n_q    <= bus.in_data;
                  csum_q <= '0;
                  bcnt_q <= '0;
                  wcnt_q <= '0;
                  if (bus.in_data == 8'd0) begin
                     state_q <= S_CHECK;
                  end else if (n_too_big) begin
                     state_q    <= S_ERROR;
                     in_ready_q <= 1'b0;
                     error_q    <= 1'b1;
                  end else begin
                     state_q <= S_RECV;
                  end
               end
            end

            S_RECV: begin
               if (accept) begin
                  word_q <= word_d;
                  csum_q <= csum_d;
                  if (last_byte) begin
                     // Load the write port now so the strobe is registered for the WRITE cycle.
                     bcnt_q         <= '0;
                     state_q        <= S_WRITE;
                     in_ready_q     <= 1'b0;
                     mem_en_write_q <= 1'b1;
                     mem_addr_q     <= wcnt_q[ADDR_SIZE-1:0];
                     mem_data_q     <= word_d;
                  end else begin
                     bcnt_q <= bcnt_q + 1'b1;
                  end
               end
            end

            S_WRITE: begin
               mem_en_write_q <= 1'b0;
               wcnt_q         <= wcnt_d;
               in_ready_q     <= 1'b1;
               state_q        <= words_done ? S_CHECK : S_RECV;
            end

            S_CHECK: begin
               if (accept) begin
                  in_ready_q <= 1'b0;
                  if (bus.in_data == csum_q) begin
                     state_q   <= S_DONE;
                     cpu_rst_q <= 1'b0;
                     done_q    <= 1'b1;
                  end else begin
                     state_q <= S_ERROR;
                     error_q <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               in_ready_q <= 1'b0;
            end

            S_ERROR: begin
               in_ready_q <= 1'b0;
            end

            default: begin
               // Unused encodings fail safe: CPU stays in reset, error raised.
               state_q        <= S_ERROR;
               in_ready_q     <= 1'b0;
               mem_en_write_q <= 1'b0;
               cpu_rst_q      <= 1'b1;
               done_q         <= 1'b0;
               error_q        <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.mem_en_write = mem_en_write_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_data     = mem_data_q;
   assign cpu_rst          = cpu_rst_q;
   assign done             = done_q;
   assign error            = error_q;
endmodule
